// File: rtl/afifo_test_pkg.sv
// Shared definitions for the asynchronous FIFO test harness agents.
// Both the read checker and the write generator import this package.
package afifo_test_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;
    localparam state_t ST_FAIL = 2'd3;

    // Fibonacci taps 16,14,13,11 expressed as state bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int ERR_COUNT_W = 16;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/afifo_lfsr16.sv
// 16-bit Fibonacci LFSR used to throttle the harness traffic agents.
// Holds its value unless advance is high; resets to the supplied seed.
module afifo_lfsr16
    import afifo_test_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = lfsr_next(state_q);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/afifo_read_checker.sv
// Read-side agent: drains a FWFT FIFO with optional pseudo-random throttling
// and checks each word against an incrementing expected sequence.
module afifo_read_checker
    import afifo_test_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    NUM_WORDS     = 1000,
    parameter logic [DATA_WIDTH-1:0] START_VALUE   = '0,
    parameter int                    THROTTLE_BITS = 0,
    parameter logic [15:0]           LFSR_SEED     = 16'hACE1,
    parameter int                    STOP_ON_ERROR = 0
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      enable,
    input  logic [DATA_WIDTH-1:0]     read_data,
    input  logic                      empty,
    output logic                      deq,
    output logic [31:0]               counter,
    output logic [2*DATA_WIDTH-1:0]   sum,
    output logic                      done,
    output logic                      error,
    output logic [ERR_COUNT_W-1:0]    err_count,
    output logic [31:0]               err_index
);

    // Low THROTTLE_BITS of the LFSR must be nonzero for a pop to be allowed.
    localparam logic [15:0] THR_MASK = 16'((32'd1 << THROTTLE_BITS) - 32'd1);

    state_t                   state_q, state_d;
    logic [31:0]              counter_q, counter_d;
    logic [2*DATA_WIDTH-1:0]  sum_q, sum_d;
    logic [DATA_WIDTH-1:0]    expected_q, expected_d;
    logic                     error_q, error_d;
    logic [ERR_COUNT_W-1:0]   err_count_q, err_count_d;
    logic [31:0]              err_index_q, err_index_d;

    logic [15:0] lfsr_state;
    logic        gate;
    logic        mismatch;

    afifo_lfsr16 u_lfsr (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .advance (state_q == ST_RUN),
        .seed    (LFSR_SEED),
        .state   (lfsr_state)
    );

    assign gate     = (THROTTLE_BITS == 0) || ((lfsr_state & THR_MASK) != 16'd0);
    assign deq      = (state_q == ST_RUN) && !empty && gate;
    assign mismatch = (read_data != expected_q);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        sum_d       = sum_q;
        expected_d  = expected_q;
        error_d     = error_q;
        err_count_d = err_count_q;
        err_index_d = err_index_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (deq) begin
                    counter_d  = counter_q + 32'd1;
                    sum_d      = sum_q + {{DATA_WIDTH{1'b0}}, read_data};
                    expected_d = expected_q + DATA_WIDTH'(1);
                    if (mismatch) begin
                        error_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_COUNT_W'(1);
                        end
                        if (!error_q) begin
                            err_index_d = counter_q;
                        end
                    end
                    // A stopping mismatch wins over reaching the word count.
                    if (mismatch && (STOP_ON_ERROR != 0)) begin
                        state_d = ST_FAIL;
                    end else if (counter_d == 32'(NUM_WORDS)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            counter_q   <= '0;
            sum_q       <= '0;
            expected_q  <= START_VALUE;
            error_q     <= 1'b0;
            err_count_q <= '0;
            err_index_q <= '0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            sum_q       <= sum_d;
            expected_q  <= expected_d;
            error_q     <= error_d;
            err_count_q <= err_count_d;
            err_index_q <= err_index_d;
        end
    end

    assign counter   = counter_q;
    assign sum       = sum_q;
    assign done      = (state_q == ST_DONE) || (state_q == ST_FAIL);
    assign error     = error_q;
    assign err_count = err_count_q;
    assign err_index = err_index_q;

endmodule

// File: tb/tb_afifo_read_checker.sv
// Directed bench: five checker instances, each fed by a small model FIFO whose
// head word is derived from the number of pops it has seen.
module tb_afifo_read_checker;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: ideal stream, later reset mid-run
    logic        en_a, empty_a, deq_a, done_a, error_a;
    logic [31:0] rd_a, counter_a, err_index_a, pop_a;
    logic [63:0] sum_a;
    logic [15:0] ec_a;
    assign rd_a = pop_a;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) pop_a <= '0; else if (deq_a) pop_a <= pop_a + 32'd1;

    afifo_read_checker #(.DATA_WIDTH(32), .NUM_WORDS(16), .START_VALUE(32'd0),
                         .THROTTLE_BITS(0), .STOP_ON_ERROR(0)) dut_a (
        .CLK(clk), .RST_N(rst_n), .enable(en_a), .read_data(rd_a), .empty(empty_a),
        .deq(deq_a), .counter(counter_a), .sum(sum_a), .done(done_a), .error(error_a),
        .err_count(ec_a), .err_index(err_index_a));

    // ---------------- instance T: throttled with random empty gaps
    logic        en_t, empty_t, deq_t, done_t, error_t;
    logic [31:0] rd_t, counter_t, err_index_t, pop_t;
    logic [63:0] sum_t;
    logic [15:0] ec_t;
    assign rd_t = pop_t;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) pop_t <= '0; else if (deq_t) pop_t <= pop_t + 32'd1;

    afifo_read_checker #(.DATA_WIDTH(32), .NUM_WORDS(100), .START_VALUE(32'd0),
                         .THROTTLE_BITS(2), .STOP_ON_ERROR(0)) dut_t (
        .CLK(clk), .RST_N(rst_n), .enable(en_t), .read_data(rd_t), .empty(empty_t),
        .deq(deq_t), .counter(counter_t), .sum(sum_t), .done(done_t), .error(error_t),
        .err_count(ec_t), .err_index(err_index_t));

    // ---------------- instance W: 8-bit wrap-around
    logic        en_w, empty_w, deq_w, done_w, error_w;
    logic [7:0]  rd_w;
    logic [31:0] counter_w, err_index_w, pop_w;
    logic [15:0] sum_w;
    logic [15:0] ec_w;
    assign rd_w = 8'hFE + pop_w[7:0];
    always @(posedge clk or negedge rst_n)
        if (!rst_n) pop_w <= '0; else if (deq_w) pop_w <= pop_w + 32'd1;

    afifo_read_checker #(.DATA_WIDTH(8), .NUM_WORDS(4), .START_VALUE(8'hFE),
                         .THROTTLE_BITS(0), .STOP_ON_ERROR(0)) dut_w (
        .CLK(clk), .RST_N(rst_n), .enable(en_w), .read_data(rd_w), .empty(empty_w),
        .deq(deq_w), .counter(counter_w), .sum(sum_w), .done(done_w), .error(error_w),
        .err_count(ec_w), .err_index(err_index_w));

    // ---------------- instance C: single corruption, keep running
    logic        en_c, empty_c, deq_c, done_c, error_c;
    logic [31:0] rd_c, counter_c, err_index_c, pop_c;
    logic [63:0] sum_c;
    logic [15:0] ec_c;
    assign rd_c = (pop_c == 32'd5) ? 32'hDEAD : pop_c;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) pop_c <= '0; else if (deq_c) pop_c <= pop_c + 32'd1;

    afifo_read_checker #(.DATA_WIDTH(32), .NUM_WORDS(10), .START_VALUE(32'd0),
                         .THROTTLE_BITS(0), .STOP_ON_ERROR(0)) dut_c (
        .CLK(clk), .RST_N(rst_n), .enable(en_c), .read_data(rd_c), .empty(empty_c),
        .deq(deq_c), .counter(counter_c), .sum(sum_c), .done(done_c), .error(error_c),
        .err_count(ec_c), .err_index(err_index_c));

    // ---------------- instance S: same corruption, stop on error
    logic        en_s, empty_s, deq_s, done_s, error_s;
    logic [31:0] rd_s, counter_s, err_index_s, pop_s;
    logic [63:0] sum_s;
    logic [15:0] ec_s;
    assign rd_s = (pop_s == 32'd5) ? 32'hDEAD : pop_s;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) pop_s <= '0; else if (deq_s) pop_s <= pop_s + 32'd1;

    afifo_read_checker #(.DATA_WIDTH(32), .NUM_WORDS(10), .START_VALUE(32'd0),
                         .THROTTLE_BITS(0), .STOP_ON_ERROR(1)) dut_s (
        .CLK(clk), .RST_N(rst_n), .enable(en_s), .read_data(rd_s), .empty(empty_s),
        .deq(deq_s), .counter(counter_s), .sum(sum_s), .done(done_s), .error(error_s),
        .err_count(ec_s), .err_index(err_index_s));

    task automatic do_reset();
        en_a = 1'b0; en_t = 1'b0; en_w = 1'b0; en_c = 1'b0; en_s = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    int ones;
    int viol;
    int cyc;

    initial begin
        en_a = 1'b0; en_t = 1'b0; en_w = 1'b0; en_c = 1'b0; en_s = 1'b0;
        empty_a = 1'b0; empty_t = 1'b1; empty_w = 1'b0; empty_c = 1'b0; empty_s = 1'b0;
        rst_n = 1'b0;

        // Reset state
        #1;
        check("rst_counter",   counter_a,   0);
        check("rst_sum",       sum_a,       0);
        check("rst_done",      done_a,      0);
        check("rst_error",     error_a,     0);
        check("rst_err_count", ec_a,        0);
        check("rst_err_index", err_index_a, 0);
        check("rst_deq",       deq_a,       0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_deq", deq_a, 0);

        // Ideal stream: 16 back-to-back pops
        en_a = 1'b1;
        ones = 0;
        repeat (16) begin
            @(negedge clk);
            if (deq_a) ones++;
        end
        check("ideal_deq_cycles", ones, 16);
        @(negedge clk);
        check("ideal_done",    done_a,    1);
        check("ideal_counter", counter_a, 16);
        check("ideal_sum",     sum_a,     120);
        check("ideal_error",   error_a,   0);
        check("ideal_deq_off", deq_a,     0);

        // Throttle plus random empty gaps
        do_reset();
        en_t = 1'b1;
        viol = 0;
        cyc  = 0;
        while (!done_t && cyc < 3000) begin
            @(negedge clk);
            empty_t = 1'($urandom_range(0, 1));
            #1;
            if (deq_t && empty_t) viol++;
            cyc++;
        end
        check("thr_done",      done_t,    1);
        check("thr_counter",   counter_t, 100);
        check("thr_sum",       sum_t,     4950);
        check("thr_error",     error_t,   0);
        check("thr_deq_empty", viol,      0);
        empty_t = 1'b0;
        repeat (3) @(negedge clk);
        check("thr_deq_after_done", deq_t, 0);

        // Wrap-around: FE+FF+00+01 = 0x1FE in the 16-bit sum
        do_reset();
        en_w = 1'b1;
        for (int i = 0; i < 50 && !done_w; i++) @(negedge clk);
        check("wrap_done",      done_w,    1);
        check("wrap_counter",   counter_w, 4);
        check("wrap_error",     error_w,   0);
        check("wrap_err_count", ec_w,      0);
        check("wrap_sum",       sum_w,     16'h01FE);

        // Single corruption: word 5 replaced by 0xDEAD
        do_reset();
        en_c = 1'b1;
        for (int i = 0; i < 50 && !done_c; i++) @(negedge clk);
        check("cor_done",      done_c,      1);
        check("cor_counter",   counter_c,   10);
        check("cor_error",     error_c,     1);
        check("cor_err_count", ec_c,        1);
        check("cor_err_index", err_index_c, 5);
        check("cor_sum",       sum_c,       64'd40 + 64'hDEAD);

        // Stop on error
        do_reset();
        en_s = 1'b1;
        for (int i = 0; i < 50 && !done_s; i++) @(negedge clk);
        check("stop_done",      done_s,      1);
        check("stop_counter",   counter_s,   6);
        check("stop_error",     error_s,     1);
        check("stop_err_index", err_index_s, 5);
        ones = 0;
        repeat (5) begin
            @(negedge clk);
            if (deq_s) ones++;
        end
        check("stop_deq_after", ones, 0);

        // Reset mid-run between clock edges
        do_reset();
        en_a = 1'b1;
        for (int i = 0; i < 100 && counter_a != 32'd7; i++) @(negedge clk);
        check("mid_counter_pre", counter_a, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_deq",     deq_a,     0);
        check("mid_rst_counter", counter_a, 0);
        check("mid_rst_sum",     sum_a,     0);
        check("mid_rst_done",    done_a,    0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100 && !done_a; i++) @(negedge clk);
        check("mid_done",    done_a,    1);
        check("mid_counter", counter_a, 16);
        check("mid_sum",     sum_a,     120);
        check("mid_error",   error_a,   0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
